// File: rtl/dff_share_arbiter_if.sv
// Requester-side bus for dff_share_arbiter: per-requester req/lock/data in,
// grant/ack plus the shared register contents out.
interface dff_share_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 8
);
    localparam int unsigned IDW = $clog2(NREQ);

    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    lock;
    logic [NREQ*DW-1:0] din;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    ack;
    logic [DW-1:0]      q;
    logic               q_valid;
    logic [IDW-1:0]     last_id;

    modport master (
        output req, lock, din,
        input  gnt, ack, q, q_valid, last_id
    );

    modport slave (
        input  req, lock, din,
        output gnt, ack, q, q_valid, last_id
    );
endinterface

// File: rtl/dff_share_arbiter.sv
// Round-robin arbiter that loads one requester word per grant into a shared
// register. Define ARB_LOCK_EN to enable burst-lock (LOCKED state).
module dff_share_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 8
) (
    input logic            clk,
    input logic            rst,
    dff_share_arbiter_if.slave bus
);
    localparam int unsigned IDW = $clog2(NREQ);

`ifdef ARB_LOCK_EN
    typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;
`else
    typedef enum logic [1:0] {IDLE, GRANT} state_t;
`endif

    state_t         state, state_n;
    logic [IDW-1:0] ptr, ptr_n;
    logic [NREQ-1:0] gnt_r, gnt_n;
    logic [NREQ-1:0] ack_r, ack_n;
    logic [DW-1:0]  q_r, q_n;
    logic           qv_r, qv_n;
    logic [IDW-1:0] id_r, id_n;

    logic [DW-1:0]  words [NREQ];
    logic           found;
    logic [IDW-1:0] win;
    logic [IDW-1:0] idx;

    function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] i);
        return NREQ'(1) << i;
    endfunction

    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
        return IDW'((32'(i) + 32'd1) % NREQ);
    endfunction

    // Unpack the flat data bus into per-requester words
    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            words[i] = bus.din[i*DW +: DW];
        end
    end

    // First pending request at or after ptr, wrapping past NREQ-1
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = IDW'((32'(ptr) + k) % NREQ);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

`ifndef ARB_LOCK_EN
    logic unused_lock;
    assign unused_lock = ^bus.lock;
`endif

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        gnt_n   = '0;
        ack_n   = '0;
        q_n     = q_r;
        qv_n    = qv_r;
        id_n    = id_r;

        unique case (state)
            IDLE: begin
                if (found) begin
                    q_n   = words[win];
                    gnt_n = onehot(win);
                    ack_n = onehot(win);
                    id_n  = win;
                    qv_n  = 1'b1;
`ifdef ARB_LOCK_EN
                    if (bus.lock[win]) begin
                        state_n = LOCKED;
                    end else begin
                        state_n = GRANT;
                        ptr_n   = next_idx(win);
                    end
`else
                    state_n = GRANT;
                    ptr_n   = next_idx(win);
`endif
                end
            end
            GRANT: begin
                state_n = IDLE;
            end
`ifdef ARB_LOCK_EN
            // Owner keeps the register; it may reload every cycle it asserts req
            LOCKED: begin
                if (bus.lock[id_r]) begin
                    gnt_n = onehot(id_r);
                    if (bus.req[id_r]) begin
                        q_n   = words[id_r];
                        ack_n = onehot(id_r);
                    end
                end else begin
                    ptr_n   = next_idx(id_r);
                    state_n = IDLE;
                end
            end
`endif
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            gnt_r <= '0;
            ack_r <= '0;
            q_r   <= '0;
            qv_r  <= 1'b0;
            id_r  <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            gnt_r <= gnt_n;
            ack_r <= ack_n;
            q_r   <= q_n;
            qv_r  <= qv_n;
            id_r  <= id_n;
        end
    end

    assign bus.gnt     = gnt_r;
    assign bus.ack     = ack_r;
    assign bus.q       = q_r;
    assign bus.q_valid = qv_r;
    assign bus.last_id = id_r;

endmodule

// File: tb/tb_dff_share_arbiter.sv
// Bench for dff_share_arbiter: directed scenarios with literal expectations,
// then random traffic checked every cycle against a behavioural model.
module tb_dff_share_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;
`ifdef ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    dff_share_arbiter_if #(.NREQ(N), .DW(DW)) bus ();

    dff_share_arbiter #(.NREQ(N), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model: phase 0 = idle, 1 = turnaround after a grant, 2 = locked burst
    int         m_phase = 0;
    int         m_ptr   = 0;
    int         m_id    = 0;
    logic [3:0] m_gnt   = '0;
    logic [3:0] m_ack   = '0;
    logic [7:0] m_q     = '0;
    logic       m_qv    = 1'b0;

    function automatic logic [7:0] word_of(input int i);
        return bus.din[i*DW +: DW];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        int w;
        if (rst) begin
            m_phase = 0; m_ptr = 0; m_id = 0;
            m_gnt = '0; m_ack = '0; m_q = '0; m_qv = 1'b0;
            return;
        end
        case (m_phase)
            0: begin
                m_gnt = '0;
                m_ack = '0;
                w = -1;
                for (int k = 0; k < N; k++) begin
                    if (w < 0 && bus.req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                end
                if (w >= 0) begin
                    m_q   = word_of(w);
                    m_gnt = 4'(1 << w);
                    m_ack = 4'(1 << w);
                    m_id  = w;
                    m_qv  = 1'b1;
                    if (LOCK_EN && bus.lock[w]) begin
                        m_phase = 2;
                    end else begin
                        m_phase = 1;
                        m_ptr   = (w + 1) % N;
                    end
                end
            end
            1: begin
                m_gnt = '0;
                m_ack = '0;
                m_phase = 0;
            end
            default: begin
                if (bus.lock[m_id]) begin
                    m_gnt = 4'(1 << m_id);
                    m_ack = bus.req[m_id] ? 4'(1 << m_id) : 4'b0;
                    if (bus.req[m_id]) m_q = word_of(m_id);
                end else begin
                    m_gnt = '0;
                    m_ack = '0;
                    m_ptr = (m_id + 1) % N;
                    m_phase = 0;
                end
            end
        endcase
    endtask

    // One clock: advance the model on the edge, compare all outputs 1 ns later
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        chk("gnt",     32'(bus.gnt),     32'(m_gnt));
        chk("ack",     32'(bus.ack),     32'(m_ack));
        chk("q",       32'(bus.q),       32'(m_q));
        chk("q_valid", 32'(bus.q_valid), 32'(m_qv));
        chk("last_id", 32'(bus.last_id), 32'(m_id));
    endtask

    task automatic set_din(input int i, input logic [7:0] v);
        bus.din[i*DW +: DW] = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        bus.req  = 4'hF;
        bus.lock = '0;
        bus.din  = '1;

        // Reset held two cycles with all requests pending
        rst = 1'b1;
        step();
        step();
        chk("rst_gnt", 32'(bus.gnt), 32'h0);
        chk("rst_ack", 32'(bus.ack), 32'h0);
        chk("rst_q", 32'(bus.q), 32'h0);
        chk("rst_qv", 32'(bus.q_valid), 32'h0);
        chk("rst_id", 32'(bus.last_id), 32'h0);
        rst = 1'b0;

        // Single request
        bus.req = 4'b0100;
        bus.din = '0;
        set_din(2, 8'hA5);
        step();
        chk("single_gnt", 32'(bus.gnt), 32'h4);
        chk("single_ack", 32'(bus.ack), 32'h4);
        chk("single_q", 32'(bus.q), 32'hA5);
        chk("single_qv", 32'(bus.q_valid), 32'h1);
        chk("single_id", 32'(bus.last_id), 32'h2);
        bus.req = 4'b0000;
        step();
        chk("single_gnt_off", 32'(bus.gnt), 32'h0);
        chk("single_ack_off", 32'(bus.ack), 32'h0);

        // Round robin with all requests held
        do_reset();
        bus.req = 4'hF;
        for (int i = 0; i < N; i++) set_din(i, 8'(8'h10 + i));
        for (int g = 0; g < 5; g++) begin
            step();
            chk("rr_ack", 32'(bus.ack), 32'(1 << (g % 4)));
            chk("rr_q", 32'(bus.q), 32'(8'h10 + (g % 4)));
            step();
            chk("rr_turn", 32'(bus.ack), 32'h0);
        end

        // Pointer wrap: after grant to 2, search 3 then 0
        do_reset();
        bus.req = 4'b0100;
        step();
        chk("wrap_first", 32'(bus.last_id), 32'h2);
        bus.req = 4'b0101;
        step();
        step();
        chk("wrap_to0", 32'(bus.ack), 32'h1);
        step();
        step();
        chk("wrap_to2", 32'(bus.ack), 32'h4);

        // Reset during the turnaround aborts and clears the pointer
        do_reset();
        bus.req = 4'b0001;
        step();
        rst = 1'b1;
        step();
        chk("midrst_gnt", 32'(bus.gnt), 32'h0);
        chk("midrst_q", 32'(bus.q), 32'h0);
        chk("midrst_qv", 32'(bus.q_valid), 32'h0);
        rst = 1'b0;
        bus.req = 4'b1001;
        step();
        chk("midrst_ptr0", 32'(bus.last_id), 32'h0);
        bus.req = 4'b1000;
        step();
        step();
        chk("midrst_req3", 32'(bus.ack), 32'h8);

        // Burst lock by requester 0 while requester 1 waits
        do_reset();
        bus.req  = 4'b0011;
        bus.lock = 4'b0001;
        bus.din  = '0;
        set_din(1, 8'h77);
        set_din(0, 8'h01);
        step();
        chk("lock_a1", 32'(bus.ack), 32'h1);
        chk("lock_q1", 32'(bus.q), 32'h01);
        set_din(0, 8'h02);
        step();
        chk("lock_a2", 32'(bus.ack), LOCK_EN ? 32'h1 : 32'h0);
        chk("lock_q2", 32'(bus.q), LOCK_EN ? 32'h02 : 32'h01);
        set_din(0, 8'h03);
        step();
        chk("lock_a3", 32'(bus.ack), LOCK_EN ? 32'h1 : 32'h2);
        chk("lock_q3", 32'(bus.q), LOCK_EN ? 32'h03 : 32'h77);
        bus.lock = 4'b0000;
        step();
        chk("lock_exit", 32'(bus.gnt), 32'h0);
        step();
        chk("lock_next", 32'(bus.ack), LOCK_EN ? 32'h2 : 32'h1);
        chk("lock_next_q", 32'(bus.q), LOCK_EN ? 32'h77 : 32'h03);

        // Random traffic, occasional resets, biased lock bursts
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(0, 199) == 0);
            bus.req  = 4'($urandom);
            bus.lock = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom);
            bus.din  = 32'($urandom);
            step();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
